// File: rtl/event_packer.sv
// Frames one sampler event into the readout FIFO as header, masked data words and trailer.
// Handles FIFO back-pressure by stalling, or by dropping whole events when DROP_ON_FULL is set.
module event_packer #(
    parameter int N_WORDS      = 16,
    parameter int HDR_EN       = 1,
    parameter int TRL_EN       = 1,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   event_ready_i,
    input  logic [64*N_WORDS-1:0]  event_i,
    input  logic [N_WORDS-1:0]     ch_mask_i,
    input  logic [31:0]            timestamp_i,
    input  logic                   full_i,
    output logic                   event_saved_o,
    output logic                   wr_en_o,
    output logic [63:0]            din_o,
    output logic                   busy_o,
    output logic [15:0]            event_cnt_o,
    output logic [15:0]            drop_cnt_o
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [63:0]        word_reg [N_WORDS];
    logic [63:0]        event_words [N_WORDS];
    logic [N_WORDS-1:0] mask_reg;
    logic [31:0]        ts_reg;
    logic [31:0]        csum_reg;
    logic [15:0]        event_cnt_reg;
    logic [15:0]        drop_cnt_reg;
    logic               saved_reg;

    logic               request;
    logic               drop_now;
    logic               accept;
    logic               cur_mask;
    logic [63:0]        cur_word;
    logic [7:0]         mask_pop;

    // A request seen during the acknowledge cycle belongs to the event just handled.
    assign request  = (state_reg == IDLE) && event_ready_i && !saved_reg;
    assign drop_now = request && (DROP_ON_FULL != 0) && full_i;
    assign accept   = request && !drop_now;

    assign cur_mask = mask_reg[idx_reg];
    assign cur_word = word_reg[idx_reg];

    generate
        for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
            assign event_words[gi] = event_i[64*gi +: 64];

            always_ff @(posedge clk) begin
                if (accept) begin
                    word_reg[gi] <= event_words[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        mask_pop = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            mask_pop = mask_pop + 8'(mask_reg[k]);
        end
    end

    always_comb begin
        wr_en_o = 1'b0;
        din_o   = '0;
        case (state_reg)
            HDR: begin
                wr_en_o = !full_i;
                din_o   = {8'hE5, mask_pop, event_cnt_reg, ts_reg};
            end
            DATA: begin
                wr_en_o = cur_mask && !full_i;
                din_o   = cur_word;
            end
            TRL: begin
                wr_en_o = !full_i;
                din_o   = {8'h5E, 8'h00, drop_cnt_reg, csum_reg};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            mask_reg      <= '0;
            ts_reg        <= '0;
            csum_reg      <= '0;
            event_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
            saved_reg     <= 1'b0;
        end else begin
            saved_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (drop_now) begin
                        saved_reg <= 1'b1;
                        if (drop_cnt_reg != 16'hFFFF) begin
                            drop_cnt_reg <= drop_cnt_reg + 16'd1;
                        end
                    end else if (accept) begin
                        saved_reg <= 1'b1;
                        mask_reg  <= ch_mask_i;
                        ts_reg    <= timestamp_i;
                        csum_reg  <= '0;
                        idx_reg   <= '0;
                        state_reg <= (HDR_EN != 0) ? HDR : DATA;
                    end
                end
                HDR: begin
                    if (!full_i) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    // A masked word is skipped in one cycle regardless of FIFO state.
                    if (wr_en_o || !cur_mask) begin
                        if (wr_en_o) begin
                            csum_reg <= csum_reg ^ cur_word[63:32] ^ cur_word[31:0];
                        end
                        if (idx_reg == LAST_IDX) begin
                            if (TRL_EN != 0) begin
                                state_reg <= TRL;
                            end else begin
                                state_reg     <= IDLE;
                                event_cnt_reg <= event_cnt_reg + 16'd1;
                            end
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                TRL: begin
                    if (!full_i) begin
                        state_reg     <= IDLE;
                        event_cnt_reg <= event_cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign event_saved_o = saved_reg;
    assign busy_o        = (state_reg != IDLE);
    assign event_cnt_o   = event_cnt_reg;
    assign drop_cnt_o    = drop_cnt_reg;

endmodule

// File: tb/tb_event_packer.sv
// Scoreboard bench for event_packer: three instances cover stall, drop and header/trailer-less configs.
// Expected frames are built from the framing rules and popped by per-instance monitors.
module tb_event_packer;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic reset;

    // instance A: defaults (stall on full)
    logic          ready_a, full_a, saved_a, wr_a, busy_a;
    logic [1023:0] event_a;
    logic [15:0]   mask_a, ecnt_a, dcnt_a;
    logic [31:0]   ts_a;
    logic [63:0]   din_a;
    // instance B: drop on full
    logic          ready_b, full_b, saved_b, wr_b, busy_b;
    logic [1023:0] event_b;
    logic [15:0]   mask_b, ecnt_b, dcnt_b;
    logic [31:0]   ts_b;
    logic [63:0]   din_b;
    // instance C: 4 words, no header, no trailer
    logic          ready_c, full_c, saved_c, wr_c, busy_c;
    logic [255:0]  event_c;
    logic [3:0]    mask_c;
    logic [15:0]   ecnt_c, dcnt_c;
    logic [31:0]   ts_c;
    logic [63:0]   din_c;

    event_packer u_a (
        .clk(clk), .reset(reset), .event_ready_i(ready_a), .event_i(event_a),
        .ch_mask_i(mask_a), .timestamp_i(ts_a), .full_i(full_a),
        .event_saved_o(saved_a), .wr_en_o(wr_a), .din_o(din_a), .busy_o(busy_a),
        .event_cnt_o(ecnt_a), .drop_cnt_o(dcnt_a)
    );

    event_packer #(.DROP_ON_FULL(1)) u_b (
        .clk(clk), .reset(reset), .event_ready_i(ready_b), .event_i(event_b),
        .ch_mask_i(mask_b), .timestamp_i(ts_b), .full_i(full_b),
        .event_saved_o(saved_b), .wr_en_o(wr_b), .din_o(din_b), .busy_o(busy_b),
        .event_cnt_o(ecnt_b), .drop_cnt_o(dcnt_b)
    );

    event_packer #(.N_WORDS(4), .HDR_EN(0), .TRL_EN(0)) u_c (
        .clk(clk), .reset(reset), .event_ready_i(ready_c), .event_i(event_c),
        .ch_mask_i(mask_c), .timestamp_i(ts_c), .full_i(full_c),
        .event_saved_o(saved_c), .wr_en_o(wr_c), .din_o(din_c), .busy_o(busy_c),
        .event_cnt_o(ecnt_c), .drop_cnt_o(dcnt_c)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          saved_n_a = 0, saved_n_b = 0, saved_n_c = 0;
    logic [63:0] q_a[$], q_b[$], q_c[$], frame_q[$];
    logic [63:0] log_a[$], log_b[$], log_c[$];
    int          wcyc_a[$];
    logic [63:0] words[16];
    logic [15:0] ecnt_m_a = 16'd0;
    logic        hold_chk = 1'b0;
    logic [63:0] prev_din_a = 64'd0;
    logic        prev_full_a = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected frame from the framing rules: header, selected words, trailer with folded XOR.
    task automatic model_frame(input logic [15:0] m, input logic [31:0] ts, input logic [15:0] ec,
                               input logic [15:0] dc, input bit hdr, input bit trl, input int n);
        logic [31:0] cs;
        int          pop;
        cs  = 32'd0;
        pop = 0;
        frame_q.delete();
        for (int k = 0; k < n; k++) begin
            if (m[k]) begin
                pop++;
                cs = cs ^ words[k][63:32] ^ words[k][31:0];
            end
        end
        if (hdr) frame_q.push_back({8'hE5, pop[7:0], ec, ts});
        for (int k = 0; k < n; k++) begin
            if (m[k]) frame_q.push_back(words[k]);
        end
        if (trl) frame_q.push_back({8'h5E, 8'h00, dc, cs});
    endtask

    always @(negedge clk) begin
        cyc++;
        if (wr_a) begin
            log_a.push_back(din_a);
            wcyc_a.push_back(cyc);
            if (q_a.size() == 0) chk("a_extra_write", 64'd1, 64'd0);
            else chk("a_word", din_a, q_a.pop_front());
        end
        if (wr_b) begin
            log_b.push_back(din_b);
            if (q_b.size() == 0) chk("b_extra_write", 64'd1, 64'd0);
            else chk("b_word", din_b, q_b.pop_front());
        end
        if (wr_c) begin
            log_c.push_back(din_c);
            if (q_c.size() == 0) chk("c_extra_write", 64'd1, 64'd0);
            else chk("c_word", din_c, q_c.pop_front());
        end
        if (saved_a) saved_n_a++;
        if (saved_b) saved_n_b++;
        if (saved_c) saved_n_c++;
        if (full_a && busy_a) chk("a_no_write_while_full", 64'(wr_a), 64'd0);
        if (hold_chk && full_a && prev_full_a) chk("a_din_hold", din_a, prev_din_a);
        prev_din_a  = din_a;
        prev_full_a = full_a;
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_words(input bit rnd);
        for (int k = 0; k < 16; k++) begin
            if (rnd) words[k] = {$urandom, $urandom};
            else     words[k] = (64'h1111_0000_0000_0000 * 64'(k)) + 64'(k);
        end
    endtask

    task automatic send_a(input logic [15:0] m, input logic [31:0] ts, input bit rand_full);
        int t;
        for (int k = 0; k < 16; k++) event_a[64*k +: 64] = words[k];
        mask_a = m;
        ts_a   = ts;
        model_frame(m, ts, ecnt_m_a, 16'd0, 1'b1, 1'b1, 16);
        foreach (frame_q[i]) q_a.push_back(frame_q[i]);
        ecnt_m_a = ecnt_m_a + 16'd1;
        ready_a = 1'b1;
        t = 0;
        while (!saved_a && t < 100) begin
            clk_step();
            t++;
            if (rand_full) full_a = ($urandom_range(0, 3) == 0);
        end
        if (!saved_a) chk("a_accept_timeout", 64'd0, 64'd1);
        ready_a = 1'b0;
    endtask

    task automatic wait_idle_a(input bit rand_full);
        int t;
        t = 0;
        while ((busy_a || q_a.size() != 0) && t < 3000) begin
            if (rand_full) full_a = ($urandom_range(0, 3) == 0);
            clk_step();
            t++;
        end
        full_a = 1'b0;
        if (t >= 3000) chk("a_frame_timeout", 64'd0, 64'd1);
        chk("a_event_cnt", 64'(ecnt_a), 64'(ecnt_m_a));
        chk("a_drop_cnt", 64'(dcnt_a), 64'd0);
    endtask

    task automatic handshake_c(output int busy_cycles);
        int t;
        ready_c = 1'b1;
        t = 0;
        while (!saved_c && t < 100) begin clk_step(); t++; end
        if (!saved_c) chk("c_accept_timeout", 64'd0, 64'd1);
        ready_c = 1'b0;
        busy_cycles = 0;
        while (busy_c && busy_cycles < 100) begin clk_step(); busy_cycles++; end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int s, sv, t, bc;
        logic [15:0] m;
        reset = 1'b1;
        {ready_a, full_a, ready_b, full_b, ready_c, full_c} = '0;
        event_a = '0; event_b = '0; event_c = '0;
        mask_a = '0; mask_b = '0; mask_c = '0;
        ts_a = '0; ts_b = '0; ts_c = '0;
        repeat (3) clk_step();
        chk("rst_wr_en", 64'(wr_a), 64'd0);
        chk("rst_din", din_a, 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_saved", 64'(saved_a), 64'd0);
        chk("rst_event_cnt", 64'(ecnt_a), 64'd0);
        chk("rst_drop_cnt", 64'(dcnt_a), 64'd0);
        reset = 1'b0;
        clk_step();

        // full mask, incrementing pattern
        fill_words(1'b0);
        s  = log_a.size();
        sv = saved_n_a;
        send_a(16'hFFFF, 32'h0000_1234, 1'b0);
        wait_idle_a(1'b0);
        chk("t1_writes", 64'(log_a.size() - s), 64'd18);
        chk("t1_header", log_a[s], 64'hE510_0000_0000_1234);
        chk("t1_back_to_back", 64'(wcyc_a[s+17] - wcyc_a[s]), 64'd17);
        chk("t1_saved_pulses", 64'(saved_n_a - sv), 64'd1);
        chk("t1_event_cnt", 64'(ecnt_a), 64'd1);

        // sparse mask: words 0 and 2 only
        fill_words(1'b1);
        s = log_a.size();
        send_a(16'h0005, $urandom, 1'b0);
        wait_idle_a(1'b0);
        chk("t2_writes", 64'(log_a.size() - s), 64'd4);
        chk("t2_hdr_count", 64'(log_a[s][55:48]), 64'd2);
        chk("t2_skip_word1", 64'(wcyc_a[s+2] - wcyc_a[s+1]), 64'd2);
        chk("t2_skip_tail", 64'(wcyc_a[s+3] - wcyc_a[s+2]), 64'd14);

        // FIFO full for DATA cycles 3..10
        fill_words(1'b1);
        s = log_a.size();
        send_a(16'hFFFF, $urandom, 1'b0);
        repeat (4) clk_step();
        full_a   = 1'b1;
        hold_chk = 1'b1;
        repeat (8) clk_step();
        full_a   = 1'b0;
        hold_chk = 1'b0;
        wait_idle_a(1'b0);
        chk("t3_writes", 64'(log_a.size() - s), 64'd18);
        chk("t3_stall_gap", 64'(wcyc_a[s+4] - wcyc_a[s+3]), 64'd9);

        // random frames with random back-pressure
        for (int n = 0; n < 20; n++) begin
            fill_words(1'b1);
            t = $urandom_range(0, 5);
            m = (t == 0) ? 16'h0000 : (t == 1) ? 16'hFFFF : 16'($urandom);
            send_a(m, $urandom, 1'b1);
            wait_idle_a(1'b1);
        end

        // drop policy: three events while full, request held through the ack cycle
        full_b = 1'b1;
        sv = saved_n_b;
        for (int n = 0; n < 3; n++) begin
            ready_b = 1'b1;
            t = 0;
            while (!saved_b && t < 100) begin clk_step(); t++; end
            if (!saved_b) chk("b_drop_ack_timeout", 64'd0, 64'd1);
            clk_step();
            ready_b = 1'b0;
            clk_step();
        end
        chk("b_drop_pulses", 64'(saved_n_b - sv), 64'd3);
        chk("b_drop_writes", 64'(log_b.size()), 64'd0);
        chk("b_drop_cnt", 64'(dcnt_b), 64'd3);
        chk("b_drop_busy", 64'(busy_b), 64'd0);
        chk("b_drop_event_cnt", 64'(ecnt_b), 64'd0);
        full_b = 1'b0;
        fill_words(1'b1);
        for (int k = 0; k < 16; k++) event_b[64*k +: 64] = words[k];
        mask_b = 16'($urandom);
        ts_b   = $urandom;
        model_frame(mask_b, ts_b, 16'd0, 16'd3, 1'b1, 1'b1, 16);
        foreach (frame_q[i]) q_b.push_back(frame_q[i]);
        ready_b = 1'b1;
        t = 0;
        while (!saved_b && t < 100) begin clk_step(); t++; end
        if (!saved_b) chk("b_accept_timeout", 64'd0, 64'd1);
        ready_b = 1'b0;
        t = 0;
        while ((busy_b || q_b.size() != 0) && t < 200) begin clk_step(); t++; end
        chk("b_trl_drop_field", 64'(log_b[log_b.size()-1][47:32]), 64'd3);
        chk("b_event_cnt", 64'(ecnt_b), 64'd1);

        // four words, no header or trailer
        fill_words(1'b1);
        for (int k = 0; k < 4; k++) event_c[64*k +: 64] = words[k];
        mask_c = 4'hF;
        ts_c   = $urandom;
        model_frame(16'h000F, ts_c, 16'd0, 16'd0, 1'b0, 1'b0, 4);
        foreach (frame_q[i]) q_c.push_back(frame_q[i]);
        ready_c = 1'b1;
        t = 0;
        while (!saved_c && t < 100) begin clk_step(); t++; end
        chk("c_first_write_with_ack", 64'(wr_c && saved_c), 64'd1);
        ready_c = 1'b0;
        bc = 0;
        while (busy_c && bc < 100) begin clk_step(); bc++; end
        chk("c_busy_cycles", 64'(bc), 64'd4);
        chk("c_writes", 64'(log_c.size()), 64'd4);
        chk("c_event_cnt", 64'(ecnt_c), 64'd1);
        mask_c = 4'h0;
        handshake_c(bc);
        chk("c_empty_busy_cycles", 64'(bc), 64'd4);
        chk("c_empty_writes", 64'(log_c.size()), 64'd4);
        chk("c_empty_event_cnt", 64'(ecnt_c), 64'd2);

        // reset while presenting DATA word 7
        fill_words(1'b1);
        send_a(16'hFFFF, $urandom, 1'b0);
        repeat (8) clk_step();
        reset = 1'b1;
        clk_step();
        chk("mid_rst_wr_en", 64'(wr_a), 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_event_cnt", 64'(ecnt_a), 64'd0);
        chk("mid_rst_drop_cnt_b", 64'(dcnt_b), 64'd0);
        q_a.delete();
        ecnt_m_a = 16'd0;
        reset = 1'b0;
        clk_step();
        fill_words(1'b1);
        s = log_a.size();
        send_a(16'hFFFF, $urandom, 1'b0);
        wait_idle_a(1'b0);
        chk("post_rst_writes", 64'(log_a.size() - s), 64'd18);
        chk("post_rst_hdr_evnum", 64'(log_a[s][47:32]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
